lsu_mc: RTL and testbench

Multi-cycle load/store unit between IEX and RF writeback, parametrised in data and memory width.
- Talks to a variable-latency data memory over a valid/ready request channel and a valid response channel.
- Stalls IEX while an access is outstanding; non-memory ops pass through in one cycle.
- Generalises the fixed-latency single-cycle LSU: byte-enabled wide-line stores, sign/zero-extended loads, misalignment handling.

---
 rtl/lsu_mc.sv | 198 +++++++++++++++++++
 tb/tb_lsu_mc.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mc.sv
// lsu_mc: multi-cycle load/store unit between IEX and RF writeback over a valid/ready dmem channel.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses complete at once with a flag instead of being aligned.
module lsu_mc #(
    parameter int  DATA_WIDTH   = 32,
    parameter int  MEM_WIDTH    = 128,
    parameter int  ADDR_WIDTH   = 32,
    parameter int  PC_WIDTH     = 32,
    parameter int  RF_DEPTH_BIT = 5,
    localparam int LANES        = MEM_WIDTH / 8,
    localparam int LANE_BITS    = $clog2(LANES)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            iex_lsu_pipe_vld,
    input  logic [PC_WIDTH-1:0]             iex_lsu_pc,
    input  logic [RF_DEPTH_BIT-1:0]         iex_lsu_rd,
    input  logic                            iex_lsu_rf_wen,
    input  logic                            iex_lsu_is_load,
    input  logic                            iex_lsu_is_store,
    input  logic [1:0]                      iex_lsu_size,
    input  logic                            iex_lsu_unsigned,
    input  logic [ADDR_WIDTH-1:0]           iex_lsu_addr,
    input  logic [DATA_WIDTH-1:0]           iex_lsu_wr_data,
    input  logic [DATA_WIDTH-1:0]           iex_lsu_cal_data,
    output logic                            lsu_iex_stall,
    output logic                            lsu_rf_pipe_vld,
    output logic [PC_WIDTH-1:0]             lsu_rf_pc,
    output logic [RF_DEPTH_BIT-1:0]         lsu_rf_rd,
    output logic                            lsu_rf_wen,
    output logic [DATA_WIDTH-1:0]           lsu_rf_wr_data,
    output logic                            lsu_rf_misalign,
    output logic                            dmem_req_vld,
    input  logic                            dmem_req_rdy,
    output logic                            dmem_req_we,
    output logic [ADDR_WIDTH-LANE_BITS-1:0] dmem_req_line,
    output logic [LANES-1:0]                dmem_req_ben,
    output logic [MEM_WIDTH-1:0]            dmem_req_wr_data,
    input  logic                            dmem_rsp_vld,
    input  logic [MEM_WIDTH-1:0]            dmem_rsp_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                    r_state;
    logic                      r_req_vld;
    logic                      r_rf_pipe_vld;
    logic [PC_WIDTH-1:0]       r_rf_pc;
    logic [RF_DEPTH_BIT-1:0]   r_rf_rd;
    logic                      r_rf_wen;
    logic [DATA_WIDTH-1:0]     r_rf_wr_data;

    logic                      w_mem_op;
    logic                      w_trap;
    logic                      w_done;
    logic [ADDR_WIDTH-1:0]     w_addr;
    logic [LANE_BITS-1:0]      w_lane;
    logic [MEM_WIDTH-1:0]      w_rsp_sh;
    logic [DATA_WIDTH-1:0]     w_ld_data;

    function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] a,
                                                         input logic [1:0] sz);
        logic [ADDR_WIDTH-1:0] r;
        r = a;
        if (sz == 2'd1)
            r[0] = 1'b0;
        else if (sz[1])
            r[1:0] = 2'b00;
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [MEM_WIDTH-1:0] sh,
                                                       input logic [1:0] sz,
                                                       input logic uns);
        case (sz)
            2'd0:    load_ext = {{(DATA_WIDTH-8){~uns & sh[7]}}, sh[7:0]};
            2'd1:    load_ext = {{(DATA_WIDTH-16){~uns & sh[15]}}, sh[15:0]};
            default: load_ext = sh[DATA_WIDTH-1:0];
        endcase
    endfunction

    function automatic logic [MEM_WIDTH-1:0] rep_data(input logic [DATA_WIDTH-1:0] d,
                                                      input logic [1:0] sz);
        case (sz)
            2'd0:    rep_data = {LANES{d[7:0]}};
            2'd1:    rep_data = {(LANES/2){d[15:0]}};
            default: rep_data = {(MEM_WIDTH/DATA_WIDTH){d}};
        endcase
    endfunction

    function automatic logic [LANES-1:0] ben_base(input logic [1:0] sz);
        case (sz)
            2'd0:    ben_base = LANES'(1);
            2'd1:    ben_base = LANES'(3);
            default: ben_base = LANES'(15);
        endcase
    endfunction

    assign w_mem_op = iex_lsu_pipe_vld & (iex_lsu_is_load | iex_lsu_is_store);

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_misalign;
    assign w_misalign = ((iex_lsu_size == 2'd1) & iex_lsu_addr[0]) |
                        ((iex_lsu_size == 2'd2) & (|iex_lsu_addr[1:0]));
    assign w_trap     = w_mem_op & w_misalign & (r_state == S_IDLE);
    assign w_addr     = iex_lsu_addr;
`else
    assign w_trap     = 1'b0;
    assign w_addr     = align_addr(iex_lsu_addr, iex_lsu_size);
`endif

    assign w_lane    = w_addr[LANE_BITS-1:0];
    assign w_done    = ((r_state == S_REQ) & dmem_req_rdy & iex_lsu_is_store) |
                       ((r_state == S_WAIT) & dmem_rsp_vld) | w_trap;
    assign w_rsp_sh  = dmem_rsp_data >> {w_lane, 3'b000};
    assign w_ld_data = load_ext(w_rsp_sh, iex_lsu_size, iex_lsu_unsigned);

    // Request fields come straight from the held IEX inputs; only valid is registered.
    assign lsu_iex_stall    = w_mem_op & ~w_done;
    assign dmem_req_vld     = r_req_vld;
    assign dmem_req_we      = iex_lsu_is_store;
    assign dmem_req_line    = w_addr[ADDR_WIDTH-1:LANE_BITS];
    assign dmem_req_ben     = iex_lsu_is_store ? (ben_base(iex_lsu_size) << w_lane) : '0;
    assign dmem_req_wr_data = rep_data(iex_lsu_wr_data, iex_lsu_size);

    assign lsu_rf_pipe_vld  = r_rf_pipe_vld;
    assign lsu_rf_pc        = r_rf_pc;
    assign lsu_rf_rd        = r_rf_rd;
    assign lsu_rf_wen       = r_rf_wen;
    assign lsu_rf_wr_data   = r_rf_wr_data;
`ifdef LSU_MISALIGN_TRAP_EN
    assign lsu_rf_misalign  = r_misalign;
`else
    assign lsu_rf_misalign  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_req_vld     <= 1'b0;
            r_rf_pipe_vld <= 1'b0;
            r_rf_pc       <= '0;
            r_rf_rd       <= '0;
            r_rf_wen      <= 1'b0;
            r_rf_wr_data  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_misalign    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op & ~w_trap) begin
                        r_state   <= S_REQ;
                        r_req_vld <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (dmem_req_rdy) begin
                        r_req_vld <= 1'b0;
                        r_state   <= iex_lsu_is_store ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dmem_rsp_vld)
                        r_state <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_req_vld <= 1'b0;
                end
            endcase

            // Writeback: completion or pass-through loads the op, otherwise a bubble.
            r_rf_pipe_vld <= 1'b0;
            if (w_mem_op & w_done) begin
                r_rf_pipe_vld <= 1'b1;
                r_rf_pc       <= iex_lsu_pc;
                r_rf_rd       <= iex_lsu_rd;
                r_rf_wen      <= iex_lsu_rf_wen & iex_lsu_is_load & ~w_trap;
                r_rf_wr_data  <= (iex_lsu_is_load & ~w_trap) ? w_ld_data : iex_lsu_cal_data;
            end else if ((r_state == S_IDLE) & iex_lsu_pipe_vld & ~w_mem_op) begin
                r_rf_pipe_vld <= 1'b1;
                r_rf_pc       <= iex_lsu_pc;
                r_rf_rd       <= iex_lsu_rd;
                r_rf_wen      <= iex_lsu_rf_wen;
                r_rf_wr_data  <= iex_lsu_cal_data;
            end
`ifdef LSU_MISALIGN_TRAP_EN
            r_misalign <= w_trap;
`endif
        end
    end

endmodule

// File: tb/tb_lsu_mc.sv
// tb_lsu_mc: randomized self-checking bench for lsu_mc against a byte-level behavioural model.
module tb_lsu_mc;
    localparam int DW = 32, MW = 128, AW = 32, PW = 32, RB = 5;
    localparam int LANES = MW / 8, LB = 4, LW = AW - LB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          iex_lsu_pipe_vld, iex_lsu_rf_wen, iex_lsu_is_load, iex_lsu_is_store, iex_lsu_unsigned;
    logic [PW-1:0] iex_lsu_pc;
    logic [RB-1:0] iex_lsu_rd;
    logic [1:0]    iex_lsu_size;
    logic [AW-1:0] iex_lsu_addr;
    logic [DW-1:0] iex_lsu_wr_data, iex_lsu_cal_data;
    logic          lsu_iex_stall, lsu_rf_pipe_vld, lsu_rf_wen, lsu_rf_misalign;
    logic [PW-1:0] lsu_rf_pc;
    logic [RB-1:0] lsu_rf_rd;
    logic [DW-1:0] lsu_rf_wr_data;
    logic          dmem_req_vld, dmem_req_rdy, dmem_req_we, dmem_rsp_vld;
    logic [LW-1:0] dmem_req_line;
    logic [LANES-1:0] dmem_req_ben;
    logic [MW-1:0] dmem_req_wr_data, dmem_rsp_data;

    lsu_mc dut (
        .clk(clk), .rst(rst),
        .iex_lsu_pipe_vld(iex_lsu_pipe_vld), .iex_lsu_pc(iex_lsu_pc), .iex_lsu_rd(iex_lsu_rd),
        .iex_lsu_rf_wen(iex_lsu_rf_wen), .iex_lsu_is_load(iex_lsu_is_load),
        .iex_lsu_is_store(iex_lsu_is_store), .iex_lsu_size(iex_lsu_size),
        .iex_lsu_unsigned(iex_lsu_unsigned), .iex_lsu_addr(iex_lsu_addr),
        .iex_lsu_wr_data(iex_lsu_wr_data), .iex_lsu_cal_data(iex_lsu_cal_data),
        .lsu_iex_stall(lsu_iex_stall), .lsu_rf_pipe_vld(lsu_rf_pipe_vld), .lsu_rf_pc(lsu_rf_pc),
        .lsu_rf_rd(lsu_rf_rd), .lsu_rf_wen(lsu_rf_wen), .lsu_rf_wr_data(lsu_rf_wr_data),
        .lsu_rf_misalign(lsu_rf_misalign), .dmem_req_vld(dmem_req_vld), .dmem_req_rdy(dmem_req_rdy),
        .dmem_req_we(dmem_req_we), .dmem_req_line(dmem_req_line), .dmem_req_ben(dmem_req_ben),
        .dmem_req_wr_data(dmem_req_wr_data), .dmem_rsp_vld(dmem_rsp_vld), .dmem_rsp_data(dmem_rsp_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_mis(input logic [31:0] a, input logic [1:0] sz);
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] eff_addr(input logic [31:0] a, input logic [1:0] sz);
        return a - (a % nbytes(sz));
    endfunction

    function automatic logic [15:0] exp_ben(input logic [31:0] ea, input logic [1:0] sz);
        logic [15:0] b;
        int lane;
        b = '0;
        lane = ea % LANES;
        for (int k = 0; k < nbytes(sz); k++) b[lane + k] = 1'b1;
        return b;
    endfunction

    function automatic logic [127:0] exp_wdata(input logic [31:0] wd, input logic [1:0] sz);
        logic [127:0] w;
        for (int k = 0; k < LANES; k++) w[8*k +: 8] = wd[8*(k % nbytes(sz)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [127:0] line, input logic [31:0] ea,
                                             input logic [1:0] sz, input bit uns);
        logic [31:0] v;
        int lane, nb;
        v = '0;
        lane = ea % LANES;
        nb = nbytes(sz);
        for (int k = 0; k < nb; k++) v[8*k +: 8] = line[8*(lane + k) +: 8];
        if (!uns && nb < 4 && v[8*nb - 1])
            for (int k = 8*nb; k < 32; k++) v[k] = 1'b1;
        return v;
    endfunction

    // Called just after a rising edge; returns just after the edge that completes the op.
    task automatic do_op(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] cal,
                         input logic [31:0] pc, input logic [4:0] rd, input bit wen,
                         input int rdy_dly, input int rsp_dly, input logic [127:0] line);
        bit mem, trap;
        logic [31:0] ea;
        mem  = ld | st;
        trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = mem && is_mis(a, sz);
`endif
        ea = eff_addr(a, sz);
        iex_lsu_pipe_vld = 1'b1; iex_lsu_is_load = ld; iex_lsu_is_store = st;
        iex_lsu_size = sz; iex_lsu_unsigned = uns; iex_lsu_addr = a; iex_lsu_wr_data = wd;
        iex_lsu_cal_data = cal; iex_lsu_pc = pc; iex_lsu_rd = rd; iex_lsu_rf_wen = wen;
        dmem_req_rdy = 1'b0; dmem_rsp_vld = 1'b0;
        #3;
        if (!mem || trap) begin
            chk("stall_nostall", lsu_iex_stall, 0);
            chk("reqvld_nostall", dmem_req_vld, 0);
            @(posedge clk); #1;
        end else begin
            chk("stall_idle", lsu_iex_stall, 1);
            chk("reqvld_idle", dmem_req_vld, 0);
            @(posedge clk); #1;
            for (int i = 0; i <= rdy_dly; i++) begin
                dmem_req_rdy = (i == rdy_dly);
                #3;
                chk("reqvld_req", dmem_req_vld, 1);
                chk("req_we", dmem_req_we, st);
                chk("req_line", dmem_req_line, ea >> LB);
                chk("req_ben", dmem_req_ben, st ? exp_ben(ea, sz) : 16'h0);
                if (st) chk("req_wdata", dmem_req_wr_data, exp_wdata(wd, sz));
                chk("stall_req", lsu_iex_stall, !(st && i == rdy_dly));
                chk("bubble_req", lsu_rf_pipe_vld, 0);
                @(posedge clk); #1;
            end
            dmem_req_rdy = 1'b0;
            if (ld) begin
                for (int j = 0; j <= rsp_dly; j++) begin
                    dmem_rsp_vld  = (j == rsp_dly);
                    dmem_rsp_data = (j == rsp_dly) ? line : {$urandom, $urandom, $urandom, $urandom};
                    #3;
                    chk("reqvld_wait", dmem_req_vld, 0);
                    chk("stall_wait", lsu_iex_stall, !(j == rsp_dly));
                    chk("bubble_wait", lsu_rf_pipe_vld, 0);
                    @(posedge clk); #1;
                end
                dmem_rsp_vld = 1'b0;
            end
        end
        chk("rf_pipe_vld", lsu_rf_pipe_vld, 1);
        chk("rf_pc", lsu_rf_pc, pc);
        chk("rf_rd", lsu_rf_rd, rd);
        chk("rf_wen", lsu_rf_wen, trap ? 1'b0 : (mem ? (ld & wen) : wen));
        chk("rf_misalign", lsu_rf_misalign, trap);
        if (!mem) chk("rf_data_pass", lsu_rf_wr_data, cal);
        else if (ld && !trap) chk("rf_data_load", lsu_rf_wr_data, exp_load(line, ea, sz, uns));
        iex_lsu_pipe_vld = 1'b0; iex_lsu_is_load = 1'b0; iex_lsu_is_store = 1'b0;
    endtask

    task automatic idle_cycle();
        iex_lsu_pipe_vld = 1'b0;
        @(posedge clk); #1;
        chk("bubble_idle", lsu_rf_pipe_vld, 0);
        chk("reqvld_idle_cyc", dmem_req_vld, 0);
    endtask

    initial begin
        logic [127:0] line;
        int kind;
        rst = 1'b1;
        iex_lsu_pipe_vld = 0; iex_lsu_is_load = 0; iex_lsu_is_store = 0; iex_lsu_size = 0;
        iex_lsu_unsigned = 0; iex_lsu_addr = 0; iex_lsu_wr_data = 0; iex_lsu_cal_data = 0;
        iex_lsu_pc = 0; iex_lsu_rd = 0; iex_lsu_rf_wen = 0;
        dmem_req_rdy = 0; dmem_rsp_vld = 0; dmem_rsp_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_reqvld", dmem_req_vld, 0);
        chk("rst_stall", lsu_iex_stall, 0);
        chk("rst_pipe_vld", lsu_rf_pipe_vld, 0);
        chk("rst_data", lsu_rf_wr_data, 0);
        chk("rst_wen", lsu_rf_wen, 0);
        chk("rst_misalign", lsu_rf_misalign, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(0, 0, 2, 0, 32'h0, 32'h0, 32'h1234, 32'h1000, 5'd5, 1, 0, 0, '0);
        chk("add_literal", lsu_rf_wr_data, 32'h1234);
        do_op(0, 1, 2, 0, 32'h104, 32'hDEADBEEF, 32'h0, 32'h1004, 5'd0, 1, 3, 0, '0);
        line = 128'h80 << 24;
        do_op(1, 0, 0, 0, 32'h203, 32'h0, 32'h0, 32'h1008, 5'd6, 1, 0, 1, line);
        chk("lb_literal", lsu_rf_wr_data, 32'hFFFFFF80);
        do_op(1, 0, 0, 1, 32'h203, 32'h0, 32'h0, 32'h100C, 5'd7, 1, 0, 1, line);
        chk("lbu_literal", lsu_rf_wr_data, 32'h00000080);
        line = {16'hBEEF, 112'h0};
        do_op(1, 0, 1, 0, 32'h10E, 32'h0, 32'h0, 32'h1010, 5'd8, 1, 1, 0, line);
        chk("lh_literal", lsu_rf_wr_data, 32'hFFFFBEEF);
        iex_lsu_pipe_vld = 1'b0; dmem_rsp_vld = 1'b1; dmem_rsp_data = {4{32'h55AA55AA}};
        @(posedge clk); #1;
        dmem_rsp_vld = 1'b0;
        chk("spurious_bubble", lsu_rf_pipe_vld, 0);
        chk("spurious_data", lsu_rf_wr_data, 32'hFFFFBEEF);
        chk("spurious_reqvld", dmem_req_vld, 0);
        line = {96'h0, 32'hCAFEF00D};
        do_op(1, 0, 2, 0, 32'h102, 32'h0, 32'h0, 32'h1014, 5'd9, 1, 0, 0, line);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_mis_flag", lsu_rf_misalign, 1);
        idle_cycle();
        chk("lw_mis_pulse", lsu_rf_misalign, 0);
`else
        chk("lw_mis_aligned", lsu_rf_wr_data, 32'hCAFEF00D);
`endif

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 2);
            line = {$urandom, $urandom, $urandom, $urandom};
            do_op(kind == 1, kind == 2, 2'($urandom_range(0, 2)), 1'($urandom), $urandom, $urandom,
                  $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom_range(0, 3),
                  $urandom_range(0, 3), line);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        // Reset while a request is pending must drop req_vld without a clock edge.
        do_op(0, 0, 2, 0, 0, 0, 32'h77, 32'h2000, 5'd3, 1, 0, 0, '0);
        iex_lsu_pipe_vld = 1; iex_lsu_is_load = 1; iex_lsu_size = 2; iex_lsu_addr = 32'h40;
        @(posedge clk); #1;
        chk("pre_rst_reqvld", dmem_req_vld, 1);
        #2; rst = 1'b1; iex_lsu_pipe_vld = 1'b0; #1;
        chk("rst_req_reqvld", dmem_req_vld, 0);
        @(posedge clk); #1; rst = 1'b0;
        iex_lsu_pipe_vld = 1; iex_lsu_is_load = 1;
        @(posedge clk); #1; dmem_req_rdy = 1'b1;
        @(posedge clk); #1; dmem_req_rdy = 1'b0;
        #2; rst = 1'b1; iex_lsu_pipe_vld = 1'b0; iex_lsu_is_load = 1'b0; #1;
        chk("rst_wait_reqvld", dmem_req_vld, 0);
        chk("rst_wait_stall", lsu_iex_stall, 0);
        chk("rst_wait_pc", lsu_rf_pc, 0);
        chk("rst_wait_rd", lsu_rf_rd, 0);
        chk("rst_wait_data", lsu_rf_wr_data, 0);
        @(posedge clk); #1; rst = 1'b0;
        dmem_rsp_vld = 1'b1; dmem_rsp_data = {4{32'h12345678}};
        @(posedge clk); #1; dmem_rsp_vld = 1'b0;
        chk("late_rsp_bubble", lsu_rf_pipe_vld, 0);
        chk("late_rsp_data", lsu_rf_wr_data, 0);
        chk("late_rsp_reqvld", dmem_req_vld, 0);
        do_op(0, 0, 2, 0, 0, 0, 32'hABCD, 32'h3000, 5'd4, 1, 0, 0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
